// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the MIPS32 memory responder.
// Imported by the responder top and its RAM.
package mips32_mem_pkg;

   localparam int DEF_DEPTH   = 1024;
   localparam int DEF_LATENCY = 2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_RD,
      OP_WR,
      OP_ERR
   } op_t;

   function automatic logic in_range(
      input logic [31:0] a,
      input int unsigned depth
   );
      return a < depth;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Datapath-side request/response bus of the memory responder.
// The datapath is the master, the responder the slave.
interface mem_responder_if;

   logic        req_rd;
   logic        req_wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        err;

   modport master (
      output req_rd,
      output req_wr,
      output addr,
      output wdata,
      input  rdata,
      input  ready,
      input  err
   );

   modport slave (
      input  req_rd,
      input  req_wr,
      input  addr,
      input  wdata,
      output rdata,
      output ready,
      output err
   );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word RAM, no reset.
// dout reflects mem[addr] as sampled on the previous edge.
module mem_array
   import mips32_mem_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   din,
   output logic [31:0]   dout
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
      dout <= mem[addr];
   end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: wait-stated word reads/writes for the datapath
// plus a debug port sharing the same RAM when the FSM is idle.
module mem_responder
   import mips32_mem_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int AW      = $clog2(DEPTH),
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic            clk,
   input  logic            rst,
   mem_responder_if.slave  bus,
   input  logic            dbg_en,
   input  logic            dbg_we,
   input  logic [AW-1:0]   dbg_addr,
   input  logic [31:0]     dbg_wdata,
   output logic [31:0]     dbg_rdata,
   output logic            dbg_ack
);

   localparam logic [3:0] LAT4 = 4'(LATENCY);

   state_t      state;
   state_t      state_n;
   op_t         op_q;
   op_t         op_n;
   op_t         sel_op;
   logic [31:0] addr_q;
   logic [31:0] addr_n;
   logic [31:0] wdata_q;
   logic [31:0] wdata_n;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  cnt;
   logic [3:0]  cnt_n;
   logic        go_done;
   logic        dbg_go;
   logic        sel_ok;

   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_din;
   logic [31:0]   mem_dout;

   logic        rd_live;
   logic        dbg_rd;
   logic [31:0] rdata_q;
   logic [31:0] dbg_rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         op_q    <= OP_RD;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         op_q    <= op_n;
         addr_q  <= addr_n;
         wdata_q <= wdata_n;
      end
   end

   // sel_* is the transaction that will touch the RAM when go_done fires
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      op_n      = op_q;
      addr_n    = addr_q;
      wdata_n   = wdata_q;
      sel_op    = op_q;
      sel_addr  = addr_q;
      sel_wdata = wdata_q;
      go_done   = 1'b0;
      dbg_go    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.req_rd || bus.req_wr) begin
               if (bus.req_rd && bus.req_wr) begin
                  op_n = OP_ERR;
               end else if (bus.req_wr) begin
                  op_n = OP_WR;
               end else begin
                  op_n = OP_RD;
               end
               addr_n    = bus.addr;
               wdata_n   = bus.wdata;
               cnt_n     = LAT4;
               sel_op    = op_n;
               sel_addr  = bus.addr;
               sel_wdata = bus.wdata;
               if (LATENCY == 0) begin
                  state_n = DONE;
                  go_done = 1'b1;
               end else begin
                  state_n = WAIT;
               end
            end else if (dbg_en) begin
               dbg_go = 1'b1;
            end
         end
         WAIT: begin
            if (cnt <= 4'd1) begin
               state_n = DONE;
               go_done = 1'b1;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign sel_ok = in_range(sel_addr, DEPTH);

   // rst gates the strobe so an abandoned transaction never commits
   always_comb begin
      mem_addr = sel_addr[AW-1:0];
      mem_din  = sel_wdata;
      mem_we   = 1'b0;
      if (dbg_go) begin
         mem_addr = dbg_addr;
         mem_din  = dbg_wdata;
         mem_we   = dbg_we && !rst;
      end else if (go_done) begin
         mem_we = (sel_op == OP_WR) && sel_ok && !rst;
      end
   end

   mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk  (clk),
      .we   (mem_we),
      .addr (mem_addr),
      .din  (mem_din),
      .dout (mem_dout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q     <= '0;
         dbg_rdata_q <= '0;
         dbg_ack     <= 1'b0;
         dbg_rd      <= 1'b0;
         rd_live     <= 1'b0;
      end else begin
         dbg_ack <= dbg_go;
         dbg_rd  <= dbg_go && !dbg_we;
         if (dbg_rd) begin
            dbg_rdata_q <= mem_dout;
         end
         if (go_done) begin
            rd_live <= (sel_op == OP_RD) && sel_ok;
            if (sel_op == OP_ERR || (sel_op == OP_RD && !sel_ok)) begin
               rdata_q <= '0;
            end
         end
         if (state == DONE && rd_live) begin
            rdata_q <= mem_dout;
         end
      end
   end

   // RAM output is live during the response cycle, then held
   assign bus.rdata = (state == DONE && rd_live) ? mem_dout : rdata_q;
   assign dbg_rdata = dbg_rd ? mem_dout : dbg_rdata_q;
   assign bus.ready = (state == DONE);
   assign bus.err   = (state == DONE)
                    && (op_q == OP_ERR || !in_range(addr_q, DEPTH));

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus a randomized
// sequence checked against a simple word-array model.
module tb_mem_responder;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int errors = 0;
   int checks = 0;

   mem_responder_if b0 ();
   mem_responder_if b1 ();

   logic        d0_en, d0_we, d0_ack;
   logic [9:0]  d0_addr;
   logic [31:0] d0_wdata, d0_rdata;
   logic        d1_en, d1_we, d1_ack;
   logic [9:0]  d1_addr;
   logic [31:0] d1_wdata, d1_rdata;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH(1024), .AW(10), .LATENCY(2)) dut0 (
      .clk       (clk),
      .rst       (rst),
      .bus       (b0),
      .dbg_en    (d0_en),
      .dbg_we    (d0_we),
      .dbg_addr  (d0_addr),
      .dbg_wdata (d0_wdata),
      .dbg_rdata (d0_rdata),
      .dbg_ack   (d0_ack)
   );

   mem_responder #(.DEPTH(1024), .AW(10), .LATENCY(0)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .bus       (b1),
      .dbg_en    (d1_en),
      .dbg_we    (d1_we),
      .dbg_addr  (d1_addr),
      .dbg_wdata (d1_wdata),
      .dbg_rdata (d1_rdata),
      .dbg_ack   (d1_ack)
   );

   task automatic set_req(input int s, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
      if (s == 0) begin
         b0.req_rd = rd; b0.req_wr = wr; b0.addr = a; b0.wdata = d;
      end else begin
         b1.req_rd = rd; b1.req_wr = wr; b1.addr = a; b1.wdata = d;
      end
   endtask

   task automatic get_out(input int s, output logic r, output logic e,
                          output logic [31:0] rv);
      if (s == 0) begin
         r = b0.ready; e = b0.err; rv = b0.rdata;
      end else begin
         r = b1.ready; e = b1.err; rv = b1.rdata;
      end
   endtask

   task automatic set_dbg(input int s, input logic en, input logic we,
                          input logic [9:0] a, input logic [31:0] d);
      if (s == 0) begin
         d0_en = en; d0_we = we; d0_addr = a; d0_wdata = d;
      end else begin
         d1_en = en; d1_we = we; d1_addr = a; d1_wdata = d;
      end
   endtask

   // one debug access; returns ack and data seen the cycle after
   task automatic dbg_op(input int s, input logic we, input logic [9:0] a,
                         input logic [31:0] d, output logic ack,
                         output logic [31:0] rv);
      set_dbg(s, 1'b1, we, a, d);
      @(posedge clk); #1;
      ack = (s == 0) ? d0_ack : d1_ack;
      rv  = (s == 0) ? d0_rdata : d1_rdata;
      set_dbg(s, 1'b0, 1'b0, '0, '0);
   endtask

   // hold a request until ready (bounded); n = edges to ready or -1
   task automatic dp_op(input int s, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output int n, output logic e,
                        output logic [31:0] rv);
      logic r;
      n = -1; e = 1'b0; rv = '0;
      set_req(s, rd, wr, a, d);
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         get_out(s, r, e, rv);
         if (r) begin
            n = i;
            break;
         end
      end
      set_req(s, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_req(0, 0, 0, '0, '0);
      set_req(1, 0, 0, '0, '0);
      set_dbg(0, 0, 0, '0, '0);
      set_dbg(1, 0, 0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({b0.ready, b0.err, d0_ack, b0.rdata, d0_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_dut0 got=%b/%b/%b %h %h exp=all zero",
                  b0.ready, b0.err, d0_ack, b0.rdata, d0_rdata);
      end
      checks++;
      if ({b1.ready, b1.err, d1_ack, b1.rdata, d1_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_dut1 got=%b/%b/%b %h %h exp=all zero",
                  b1.ready, b1.err, d1_ack, b1.rdata, d1_rdata);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_preload_read();
      logic ack, e;
      logic [31:0] rv;
      int n;
      dbg_op(0, 1'b1, 10'd120, 32'd85, ack, rv);
      checks++;
      if (ack !== 1'b1) begin
         errors++;
         $display("FAIL preload_ack got=%b exp=1", ack);
      end
      dp_op(0, 1'b1, 1'b0, 32'd120, '0, n, e, rv);
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL preload_latency got=%0d exp=3", n);
      end
      checks++;
      if (rv !== 32'd85 || e !== 1'b0) begin
         errors++;
         $display("FAIL preload_rdata got=%h err=%b exp=%h err=0",
                  rv, e, 32'd85);
      end
   endtask

   task automatic test_write_path();
      logic ack, e;
      logic [31:0] rv;
      int n;
      dp_op(0, 1'b0, 1'b1, 32'd121, 32'd130, n, e, rv);
      checks++;
      if (n != 3 || e !== 1'b0) begin
         errors++;
         $display("FAIL write_ready got=%0d err=%b exp=3 err=0", n, e);
      end
      dbg_op(0, 1'b0, 10'd121, '0, ack, rv);
      checks++;
      if (ack !== 1'b1 || rv !== 32'd130) begin
         errors++;
         $display("FAIL write_readback got=%b %h exp=1 %h", ack, rv, 32'd130);
      end
   endtask

   task automatic test_errors();
      logic ack, e;
      logic [31:0] rv;
      int n;
      dbg_op(0, 1'b1, 10'd200, 32'hCAFE, ack, rv);
      dp_op(0, 1'b1, 1'b0, 32'd120, '0, n, e, rv);
      dp_op(0, 1'b1, 1'b1, 32'd200, 32'd55, n, e, rv);
      checks++;
      if (n < 1 || e !== 1'b1 || rv !== '0) begin
         errors++;
         $display("FAIL both_req got=n%0d err=%b rd=%h exp=ready err=1 rd=0",
                  n, e, rv);
      end
      dbg_op(0, 1'b0, 10'd200, '0, ack, rv);
      checks++;
      if (rv !== 32'hCAFE) begin
         errors++;
         $display("FAIL both_req_mem got=%h exp=%h", rv, 32'hCAFE);
      end
      dp_op(0, 1'b1, 1'b0, 32'd120, '0, n, e, rv);
      dp_op(0, 1'b1, 1'b0, 32'd1024, '0, n, e, rv);
      checks++;
      if (n != 3 || e !== 1'b1 || rv !== '0) begin
         errors++;
         $display("FAIL oor_read got=n%0d err=%b rd=%h exp=3 err=1 rd=0",
                  n, e, rv);
      end
      dp_op(0, 1'b0, 1'b1, 32'h8000_0078, 32'd1, n, e, rv);
      checks++;
      if (n != 3 || e !== 1'b1) begin
         errors++;
         $display("FAIL oor_write got=n%0d err=%b exp=3 err=1", n, e);
      end
      dbg_op(0, 1'b0, 10'd120, '0, ack, rv);
      checks++;
      if (rv !== 32'd85) begin
         errors++;
         $display("FAIL oor_write_dropped got=%h exp=%h", rv, 32'd85);
      end
   endtask

   task automatic b2b(input int s, input int lat);
      logic ack, r, e;
      logic [31:0] rv, dt1, dt2;
      int t1, t2;
      dbg_op(s, 1'b1, 10'd0, 32'h28010078, ack, rv);
      dbg_op(s, 1'b1, 10'd1, 32'h20220000, ack, rv);
      t1 = -1; t2 = -1; dt1 = '0; dt2 = '0;
      set_req(s, 1'b1, 1'b0, 32'd0, '0);
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         get_out(s, r, e, rv);
         if (r) begin
            if (t1 < 0) begin
               t1 = i; dt1 = rv;
               set_req(s, 1'b1, 1'b0, 32'd1, '0);
            end else begin
               t2 = i; dt2 = rv;
               break;
            end
         end
      end
      set_req(s, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
      checks++;
      if (t1 != lat + 1 || t2 - t1 != lat + 2) begin
         errors++;
         $display("FAIL b2b_timing lat=%0d got=%0d,%0d exp=%0d,+%0d",
                  lat, t1, t2, lat + 1, lat + 2);
      end
      checks++;
      if (dt1 !== 32'h28010078 || dt2 !== 32'h20220000) begin
         errors++;
         $display("FAIL b2b_data lat=%0d got=%h,%h exp=28010078,20220000",
                  lat, dt1, dt2);
      end
   endtask

   task automatic test_back_to_back();
      b2b(0, 2);
      b2b(1, 0);
   endtask

   task automatic test_reset_mid_op();
      logic ack;
      logic [31:0] rv, old;
      int pulses;
      old = $urandom | 32'h100;
      dbg_op(0, 1'b1, 10'd5, old, ack, rv);
      set_req(0, 1'b0, 1'b1, 32'd5, 32'd7);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      set_req(0, 1'b0, 1'b0, '0, '0);
      checks++;
      if ({b0.ready, b0.err, d0_ack, b0.rdata, d0_rdata} !== '0) begin
         errors++;
         $display("FAIL midrst_outputs got=%b/%b/%b %h %h exp=all zero",
                  b0.ready, b0.err, d0_ack, b0.rdata, d0_rdata);
      end
      pulses = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (b0.ready) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL midrst_ready got=%0d pulses exp=0", pulses);
      end
      dbg_op(0, 1'b0, 10'd5, '0, ack, rv);
      checks++;
      if (ack !== 1'b1 || rv !== old) begin
         errors++;
         $display("FAIL midrst_mem got=%b %h exp=1 %h", ack, rv, old);
      end
   endtask

   task automatic test_arbitration();
      logic ack;
      logic [31:0] rv, v;
      int n, acks;
      v = $urandom;
      dbg_op(0, 1'b1, 10'd30, v, ack, rv);
      set_req(0, 1'b1, 1'b0, 32'd30, '0);
      set_dbg(0, 1'b1, 1'b0, 10'd30, '0);
      n = -1; acks = 0; rv = '0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (d0_ack) acks++;
         if (i == 1) set_dbg(0, 1'b0, 1'b0, '0, '0);
         if (b0.ready) begin
            n = i; rv = b0.rdata;
            break;
         end
      end
      set_req(0, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
      if (d0_ack) acks++;
      checks++;
      if (acks != 0 || n != 3 || rv !== v) begin
         errors++;
         $display("FAIL arb_dp got=acks%0d n%0d rd=%h exp=acks0 n3 rd=%h",
                  acks, n, rv, v);
      end
      dbg_op(0, 1'b0, 10'd30, '0, ack, rv);
      checks++;
      if (ack !== 1'b1 || rv !== v) begin
         errors++;
         $display("FAIL arb_retry got=%b %h exp=1 %h", ack, rv, v);
      end
   endtask

   task automatic test_random();
      logic [31:0] mdl [16];
      logic [31:0] exp_rd, a, d, rv;
      logic ack, e, wr;
      int n;
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         dbg_op(0, 1'b1, 10'(i), d, ack, rv);
         mdl[i] = d;
      end
      dp_op(0, 1'b1, 1'b0, 32'd0, '0, n, e, rv);
      exp_rd = mdl[0];
      checks++;
      if (rv !== exp_rd) begin
         errors++;
         $display("FAIL rnd_first got=%h exp=%h", rv, exp_rd);
      end
      for (int it = 0; it < 60; it++) begin
         int k;
         k = int'($urandom_range(0, 5));
         a = 32'($urandom_range(0, 15));
         d = $urandom;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         checks++;
         case (k)
            0: begin
               dbg_op(0, 1'b1, a[9:0], d, ack, rv);
               mdl[a[3:0]] = d;
               if (ack !== 1'b1) begin
                  errors++;
                  $display("FAIL rnd_dbg_wr it=%0d ack=%b exp=1", it, ack);
               end
            end
            1: begin
               dbg_op(0, 1'b0, a[9:0], '0, ack, rv);
               if (ack !== 1'b1 || rv !== mdl[a[3:0]]) begin
                  errors++;
                  $display("FAIL rnd_dbg_rd it=%0d got=%b %h exp=1 %h",
                           it, ack, rv, mdl[a[3:0]]);
               end
            end
            2: begin
               dp_op(0, 1'b1, 1'b0, a, '0, n, e, rv);
               exp_rd = mdl[a[3:0]];
               if (n != 3 || e !== 1'b0 || rv !== exp_rd) begin
                  errors++;
                  $display("FAIL rnd_rd it=%0d got=n%0d e%b %h exp=n3 e0 %h",
                           it, n, e, rv, exp_rd);
               end
            end
            3: begin
               dp_op(0, 1'b0, 1'b1, a, d, n, e, rv);
               mdl[a[3:0]] = d;
               if (n != 3 || e !== 1'b0 || rv !== exp_rd) begin
                  errors++;
                  $display("FAIL rnd_wr it=%0d got=n%0d e%b %h exp=n3 e0 %h",
                           it, n, e, rv, exp_rd);
               end
            end
            4: begin
               dp_op(0, 1'b1, 1'b1, a, d, n, e, rv);
               exp_rd = '0;
               if (n < 1 || e !== 1'b1 || rv !== exp_rd) begin
                  errors++;
                  $display("FAIL rnd_both it=%0d got=n%0d e%b %h exp=e1 0",
                           it, n, e, rv);
               end
            end
            default: begin
               a = 32'd1024 + $urandom_range(0, 32'h7FFF_0000);
               wr = 1'($urandom_range(0, 1));
               dp_op(0, !wr, wr, a, d, n, e, rv);
               if (!wr) exp_rd = '0;
               if (n != 3 || e !== 1'b1 || rv !== exp_rd) begin
                  errors++;
                  $display("FAIL rnd_oor it=%0d a=%h got=n%0d e%b %h exp=n3 e1 %h",
                           it, a, n, e, rv, exp_rd);
               end
            end
         endcase
      end
   endtask

   initial begin
      test_reset();
      test_preload_read();
      test_write_path();
      test_errors();
      test_back_to_back();
      test_reset_mid_op();
      test_arbitration();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder (slave) end of the MIPS32 datapath memory interface: services word reads and writes issued on ReadM/WriteM-style strobes, inserting configurable wait states and returning a ready handshake.
- Adds a debug port so benches preload programs and data (e.g. Mem[120]=85) and read results back (e.g. Mem[121]) through ports rather than hierarchical writes.
- Sits between MIPS_datapath and the word-addressed unified instruction/data memory.

Parameters:
- DEPTH, 1024, number of 32-bit words; addresses are word indices.
- AW, 10, address width (clog2(DEPTH)); the addr port is 32 bits, upper bits checked for range.
- LATENCY, 2, wait-state cycles between request capture and ready (0..15).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- req_rd  input  1  read request from datapath (ReadM)
- req_wr  input  1  write request from datapath (WriteM)
- addr  input  32  word address
- wdata  input  32  write data
- rdata  output  32  read data, valid while ready=1
- ready  output  1  one-cycle completion pulse
- err  output  1  one-cycle error pulse, coincident with ready
- dbg_en  input  1  debug access strobe
- dbg_we  input  1  debug write (1) / read (0)
- dbg_addr  input  AW  debug word address
- dbg_wdata  input  32  debug write data
- dbg_rdata  output  32  debug read data, valid while dbg_ack=1
- dbg_ack  output  1  debug access accepted (one cycle after dbg_en)

Behaviour:
- FSM states: IDLE, WAIT, DONE.
- Reset: state=IDLE; ready, err, dbg_ack = 0; rdata and dbg_rdata = 0; counter = 0. Memory array is not cleared.
- IDLE, req_rd xor req_wr high:
  - Capture op, addr and wdata; counter=LATENCY.
  - Go to WAIT, or to DONE when LATENCY=0.
- IDLE, req_rd and req_wr both high: capture as an error op; no array access; DONE with err=1 and rdata=0.
- WAIT: decrement counter each cycle; at counter==1 go to DONE.
- Array access timing:
  - The array access happens on the edge entering DONE.
  - A write commits on that edge; a read is registered into rdata on that edge.
- DONE: ready=1 for exactly one cycle, then IDLE.
- Request timing:
  - Latency: request sampled at edge N, ready high in cycle N+LATENCY+1.
  - The requester holds req and addr stable until it sees ready. Changes while in WAIT are ignored (captured values are used).
  - After DONE, a request still high in IDLE is taken as a new transaction. Minimum spacing between ready pulses is LATENCY+2 cycles.
- Range check: addr >= DEPTH gives err=1 with ready; reads return 0 and writes are dropped.
- rdata keeps its last value outside DONE. It is cleared only by reset or an error/out-of-range read.
- Debug port:
  - Accepted only in IDLE when neither req is high; datapath requests have priority.
  - When accepted: dbg_ack=1 on the next cycle. A read returns dbg_rdata on that cycle; a write commits on the acceptance edge.
  - If dbg_en is not accepted, dbg_ack=0 and the bench must retry.
  - A datapath request arriving in the same cycle as dbg_en wins; the debug access is not queued.
- rst mid-transaction (WAIT or DONE): abandon it with no write commit if not yet in DONE; ready is never asserted for it.

Decomposition:
- Package mips32_mem_pkg:
  - state enum (IDLE, WAIT, DONE)
  - op enum (OP_RD, OP_WR, OP_ERR)
  - default DEPTH/LATENCY constants
- Sub-module mem_array: single-port synchronous 32-bit RAM with we, addr, din, dout and no reset. One instance is shared by the datapath and debug paths through a mux controlled by the FSM.

Test Plan:
- Preload via debug: dbg write 120<-85, then datapath req_rd addr=120 with LATENCY=2. Required: ready exactly 3 cycles after capture, rdata=85, err=0.
- Write path: req_wr addr=121 wdata=130, hold until ready, then dbg read 121. Required: dbg_ack next cycle, dbg_rdata=130.
- Error cases:
  - req_rd and req_wr both high: ready and err high, rdata=0, Mem[addr] unchanged.
  - req_rd addr=1024: ready and err high, rdata=0.
- Back-to-back: req_rd held high across two transactions (addr 0 then 1, holding 32'h28010078 and 32'h20220000). Required: two ready pulses 4 cycles apart with the correct data; LATENCY=0 build gives pulses 2 cycles apart.
- Reset mid-op: req_wr addr=5 wdata=7, assert rst during WAIT. Required: no ready; Mem[5] unchanged on dbg read; state IDLE; outputs 0.
- Arbitration: dbg_en and req_rd in the same IDLE cycle. Required: datapath served, dbg_ack=0; dbg retry after ready succeeds.
